// File: rtl/hilo_div_unit.sv
// HI/LO register pair with W-stage mthi/mtlo writes, bypassed mfhi/mflo reads
// and an iterative radix-2 restoring divider that stalls the pipeline.
module hilo_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             DataMoveW,
   input  logic             WriteHiLoW,
   input  logic             HiorLoW,
   input  logic [WIDTH-1:0] wdataW,
   input  logic             rd_hilo,
   output logic [WIDTH-1:0] rdata,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_a,
   input  logic [WIDTH-1:0] div_b,
   input  logic             div_cancel,
   output logic             div_stall,
   output logic             div_busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } state_t;

   state_t           state;
   state_t           stateNext;
   logic [CW-1:0]    counter;
   logic             doneFlag;
   logic [WIDTH-1:0] hiReg;
   logic [WIDTH-1:0] loReg;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic             signQ;
   logic             signR;

   logic             mtWrite;
   logic             startOk;
   logic             divWrite;
   logic             stepLast;
   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH:0]   remShift;
   logic [WIDTH:0]   remDiff;
   logic             remGe;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoFinal;
   logic [WIDTH-1:0] remFinal;

   assign mtWrite = DataMoveW & WriteHiLoW;

   assign rdata = (mtWrite && (HiorLoW == rd_hilo)) ? wdataW
                : (rd_hilo ? hiReg : loReg);

   assign absA = (div_signed && div_a[WIDTH-1]) ? -div_a : div_a;
   assign absB = (div_signed && div_b[WIDTH-1]) ? -div_b : div_b;

   // quo doubles as the dividend shifter: its MSB feeds the remainder
   assign remShift = {rem, quo[WIDTH-1]};
   assign remDiff  = remShift - {1'b0, divisor};
   assign remGe    = (remShift >= {1'b0, divisor});
   assign remNext  = remGe ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];

   assign quoFinal = signQ ? -quo : quo;
   assign remFinal = signR ? -rem : rem;

   assign startOk  = div_start & ~doneFlag & ~div_cancel;
   assign stepLast = (counter == CW'(WIDTH - 1));

   assign div_busy  = (state != IDLE);
   assign div_stall = (state != IDLE) | (div_start & ~doneFlag);

   always_comb begin
      stateNext = state;
      divWrite  = 1'b0;
      unique case (state)
         IDLE: begin
            if (startOk) stateNext = DIV;
         end
         DIV: begin
            if (div_cancel)    stateNext = IDLE;
            else if (stepLast) stateNext = DONE;
         end
         DONE: begin
            stateNext = IDLE;
            if (!div_cancel) divWrite = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         counter  <= '0;
         doneFlag <= 1'b0;
         divisor  <= '0;
         rem      <= '0;
         quo      <= '0;
         signQ    <= 1'b0;
         signR    <= 1'b0;
      end else begin
         state    <= stateNext;
         doneFlag <= divWrite;
         if (state == IDLE && startOk) begin
            divisor <= absB;
            quo     <= absA;
            rem     <= '0;
            counter <= '0;
            signQ   <= div_signed & (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
            signR   <= div_signed & div_a[WIDTH-1];
         end else if (state == DIV) begin
            rem     <= remNext;
            quo     <= {quo[WIDTH-2:0], remGe};
            counter <= counter + CW'(1);
         end
      end
   end

   // divider completion takes priority over a same-edge mthi/mtlo
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hiReg <= '0;
         loReg <= '0;
      end else if (divWrite) begin
         hiReg <= remFinal;
         loReg <= quoFinal;
      end else if (mtWrite) begin
         if (HiorLoW) hiReg <= wdataW;
         else         loReg <= wdataW;
      end
   end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Bench for hilo_div_unit: vector table of divides with a result
// scoreboard, plus hand sequences for bypass, cancel, reset and priority.
module tb_hilo_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         DataMoveW = 1'b0;
   logic         WriteHiLoW = 1'b0;
   logic         HiorLoW = 1'b0;
   logic [W-1:0] wdataW = '0;
   logic         rd_hilo = 1'b0;
   logic [W-1:0] rdata;
   logic         div_start = 1'b0;
   logic         div_signed = 1'b0;
   logic [W-1:0] div_a = '0;
   logic [W-1:0] div_b = '0;
   logic         div_cancel = 1'b0;
   logic         div_stall;
   logic         div_busy;

   hilo_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .DataMoveW(DataMoveW), .WriteHiLoW(WriteHiLoW),
      .HiorLoW(HiorLoW), .wdataW(wdataW),
      .rd_hilo(rd_hilo), .rdata(rdata),
      .div_start(div_start), .div_signed(div_signed),
      .div_a(div_a), .div_b(div_b), .div_cancel(div_cancel),
      .div_stall(div_stall), .div_busy(div_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] expLo;
      logic [W-1:0] expHi;
   } vec_t;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];
   int tests = 0;
   int fails = 0;
   logic [W-1:0] curLo, curHi;

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic readHiLo(output logic [W-1:0] lo, output logic [W-1:0] hi);
      rd_hilo = 1'b0;
      #1 lo = rdata;
      rd_hilo = 1'b1;
      #1 hi = rdata;
   endtask

   task automatic mtWrite(input logic toHi, input logic [W-1:0] d);
      @(negedge clk);
      DataMoveW  = 1'b1;
      WriteHiLoW = 1'b1;
      HiorLoW    = toHi;
      wdataW     = d;
      @(negedge clk);
      DataMoveW  = 1'b0;
      WriteHiLoW = 1'b0;
   endtask

   task automatic runDiv(input vec_t v, input string name);
      int n;
      exp_t e;
      logic [W-1:0] lo, hi;
      @(negedge clk);
      readHiLo(lo, hi);
      check({name, " lo before"}, lo, curLo);
      check({name, " hi before"}, hi, curHi);
      div_signed = v.sgn;
      div_a = v.a;
      div_b = v.b;
      div_start = 1'b1;
      sb.push_back('{lo: v.expLo, hi: v.expHi});
      n = 0;
      #1;
      while (div_stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check({name, " stall cycles"}, W'(n), W'(34));
      check({name, " busy after"}, W'(div_busy), W'(0));
      @(negedge clk);
      #1;
      check({name, " no reissue"}, W'(div_busy), W'(0));
      div_start = 1'b0;
      e = sb.pop_front();
      readHiLo(lo, hi);
      check({name, " lo"}, lo, e.lo);
      check({name, " hi"}, hi, e.hi);
      curLo = e.lo;
      curHi = e.hi;
   endtask

   task automatic prioTest(input logic toHi, input string name);
      logic [W-1:0] lo, hi;
      @(negedge clk);
      div_signed = 1'b0;
      div_a = 32'd100;
      div_b = 32'd7;
      div_start = 1'b1;
      repeat (33) @(negedge clk);
      #1;
      check({name, " busy in done"}, W'(div_busy), W'(1));
      DataMoveW  = 1'b1;
      WriteHiLoW = 1'b1;
      HiorLoW    = toHi;
      wdataW     = 32'hDEADBEEF;
      @(negedge clk);
      DataMoveW  = 1'b0;
      WriteHiLoW = 1'b0;
      div_start  = 1'b0;
      readHiLo(lo, hi);
      check({name, " lo"}, lo, 32'd14);
      check({name, " hi"}, hi, 32'd2);
      curLo = 32'd14;
      curHi = 32'd2;
   endtask

   initial begin
      logic [W-1:0] lo, hi;

      vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2};
      vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF};
      vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
      vecs[3] = '{1'b0, 32'h55, 32'h0, 32'hFFFFFFFF, 32'h55};
      vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0};
      vecs[5] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
      vecs[6] = '{1'b0, 32'd5, 32'd10, 32'd0, 32'd5};
      vecs[7] = '{1'b1, 32'hFFFFFF9C, 32'h0, 32'd1, 32'hFFFFFF9C};

      @(negedge clk);
      readHiLo(lo, hi);
      check("reset lo", lo, 32'h0);
      check("reset hi", hi, 32'h0);
      check("reset stall", W'(div_stall), W'(0));
      check("reset busy", W'(div_busy), W'(0));
      rst = 1'b1;

      // mtlo bypass in the write cycle, then the registered value
      @(negedge clk);
      DataMoveW  = 1'b1;
      WriteHiLoW = 1'b1;
      HiorLoW    = 1'b0;
      wdataW     = 32'h12345678;
      readHiLo(lo, hi);
      check("mtlo bypass", lo, 32'h12345678);
      check("mtlo hi untouched", hi, 32'h0);
      @(negedge clk);
      DataMoveW  = 1'b0;
      WriteHiLoW = 1'b0;
      readHiLo(lo, hi);
      check("mtlo reg", lo, 32'h12345678);
      curLo = 32'h12345678;
      curHi = 32'h0;

      for (int i = 0; i < 8; i++)
         runDiv(vecs[i], $sformatf("vec%0d", i));

      // cancel mid-divide leaves HI/LO alone
      mtWrite(1'b1, 32'hCAFE0001);
      mtWrite(1'b0, 32'hBEEF0002);
      @(negedge clk);
      div_signed = 1'b0;
      div_a = 32'd100;
      div_b = 32'd7;
      div_start = 1'b1;
      repeat (10) @(negedge clk);
      div_cancel = 1'b1;
      div_start  = 1'b0;
      @(negedge clk);
      div_cancel = 1'b0;
      #1;
      check("cancel stall", W'(div_stall), W'(0));
      check("cancel busy", W'(div_busy), W'(0));
      repeat (40) @(negedge clk);
      readHiLo(lo, hi);
      check("cancel lo", lo, 32'hBEEF0002);
      check("cancel hi", hi, 32'hCAFE0001);

      // async reset mid-divide
      @(negedge clk);
      div_a = 32'hFFFFFFF0;
      div_b = 32'd3;
      div_start = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      rst = 1'b0;
      div_start = 1'b0;
      #1;
      check("rst busy", W'(div_busy), W'(0));
      check("rst stall", W'(div_stall), W'(0));
      readHiLo(lo, hi);
      check("rst lo", lo, 32'h0);
      check("rst hi", hi, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      readHiLo(lo, hi);
      check("post rst lo", lo, 32'h0);
      mtWrite(1'b1, 32'hA5A5A5A5);
      readHiLo(lo, hi);
      check("mthi after rst", hi, 32'hA5A5A5A5);

      prioTest(1'b1, "prio hi");
      prioTest(1'b0, "prio lo");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
